// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default operand/result width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor built from gate primitives.
//   a      : minuend bit
//   b      : subtrahend bit
//   diff   : a ^ b
//   borrow : ~a & b
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  logic a_n_s;

  xor g_diff   (diff, a, b);
  not g_inv    (a_n_s, a);
  and g_borrow (borrow, a_n_s, b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, LSB first,
// one bit per clock with a single borrow flip-flop.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while busy = 0 (IDLE or DONE)
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high during the WIDTH shift cycles
//   done       : one-cycle pulse when diff/borrow_out are valid
//   diff       : result, held until the next accepted start
//   borrow_out : final borrow, high when a < b
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             borrow_out_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             last_s;
  logic             d1_s;
  logic             br1_s;
  logic             br2_s;
  logic             d_s;
  logic             borrow_next_s;

  // Full-subtract bit cell: a_bit - b_bit first, then subtract the borrow.
  half_subtractor u_hs_ab (
    .a      (a_sr_r[0]),
    .b      (b_sr_r[0]),
    .diff   (d1_s),
    .borrow (br1_s)
  );

  half_subtractor u_hs_br (
    .a      (d1_s),
    .b      (borrow_r),
    .diff   (d_s),
    .borrow (br2_s)
  );

  assign borrow_next_s = br1_s | br2_s;

  // Next-state logic; start is honoured only in IDLE and DONE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = SHIFT;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_CNT) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = SHIFT;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand capture, serial shift, borrow and cycle counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_r       <= '0;
      b_sr_r       <= '0;
      diff_r       <= '0;
      cnt_r        <= '0;
      borrow_r     <= 1'b0;
      borrow_out_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      // Status flags are registered from the next state so they line up with it.
      busy_r <= (state_s == SHIFT);
      done_r <= (state_s == DONE);
      if (accept_s) begin
        a_sr_r   <= a;
        b_sr_r   <= b;
        borrow_r <= 1'b0;
        cnt_r    <= '0;
      end else if (state_r == SHIFT) begin
        a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
        b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
        diff_r   <= {d_s, diff_r[WIDTH-1:1]};
        borrow_r <= borrow_next_s;
        // Hold on the terminal count so the counter never wraps.
        if (!last_s) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        // The final borrow is the one leaving the MSB step.
        if (last_s) begin
          borrow_out_r <= borrow_next_s;
        end
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // An operation accepted at edge e0 occupies the block until edge e0+W+1,
  // busy follows edges e0..e0+W-1 and the result appears after edge e0+W.
  int           edge_cnt    = 0;
  int           free_at     = 0;
  int           done_edge   = -1;
  logic [W-1:0] pend_diff   = '0;
  logic         pend_borrow = 1'b0;
  logic [W-1:0] exp_diff    = '0;
  logic         exp_borrow  = 1'b0;
  logic         exp_busy    = 1'b0;
  logic         exp_done    = 1'b0;
  logic         model_valid = 1'b0;
  int           done_count  = 0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (rst) begin
      model_valid <= 1'b1;
      free_at     <= 0;
      done_edge   <= -1;
      exp_diff    <= '0;
      exp_borrow  <= 1'b0;
      exp_busy    <= 1'b0;
      exp_done    <= 1'b0;
    end else begin
      if (start && edge_cnt >= free_at) begin
        free_at     <= edge_cnt + W + 1;
        done_edge   <= edge_cnt + W;
        pend_diff   <= a - b;
        pend_borrow <= (a < b);
        exp_busy    <= 1'b1;
      end else begin
        exp_busy    <= (edge_cnt < free_at - 1);
      end
      exp_done <= (edge_cnt == done_edge);
      if (edge_cnt == done_edge) begin
        exp_diff   <= pend_diff;
        exp_borrow <= pend_borrow;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if (!exp_busy) begin
        chk("diff", {24'd0, diff}, {24'd0, exp_diff});
        chk("borrow_out", {31'd0, borrow_out}, {31'd0, exp_borrow});
      end
    end
    if (done === 1'b1) done_count <= done_count + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 30);
    if (done !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb);
    int n;
    start = 1'b1;
    a = av;
    b = bv;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_done(name, n);
    chk({name, "_latency"}, n + 1, 32'd9);
    chk({name, "_diff"}, {24'd0, diff}, {24'd0, ed});
    chk({name, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
    tick();
  endtask

  initial begin
    int n;
    int dc0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed arithmetic vectors
    run_op("v05_03", 8'h05, 8'h03, 8'h02, 1'b0);
    run_op("v03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
    run_op("v00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("vFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op("v80_7F", 8'h80, 8'h7F, 8'h01, 1'b0);

    // Start while busy is ignored
    dc0 = done_count;
    start = 1'b1; a = 8'h10; b = 8'h01;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'h00; b = 8'h00;
    tick();
    start = 1'b0;
    wait_done("ignore", n);
    chk("ignore_latency", n + 4, 32'd9);
    chk("ignore_diff", {24'd0, diff}, 32'h0F);
    chk("ignore_borrow", {31'd0, borrow_out}, 32'd0);
    repeat (12) tick();
    chk("ignore_one_done", done_count - dc0, 32'd1);

    // Reset in the middle of SHIFT
    start = 1'b1; a = 8'h55; b = 8'h11;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_diff", {24'd0, diff}, 32'd0);
    chk("midrst_borrow", {31'd0, borrow_out}, 32'd0);
    dc0 = done_count;
    repeat (12) tick();
    chk("midrst_no_done", done_count - dc0, 32'd0);
    run_op("v09_04", 8'h09, 8'h04, 8'h05, 1'b0);

    // Back-to-back: start held high across the DONE cycle
    start = 1'b1; a = 8'h30; b = 8'h10;
    tick();
    a = 8'h20; b = 8'h21;
    wait_done("b2b_first", n);
    chk("b2b_first_diff", {24'd0, diff}, 32'h20);
    chk("b2b_first_borrow", {31'd0, borrow_out}, 32'd0);
    tick();
    start = 1'b0;
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_second", n);
    chk("b2b_spacing", n + 1, 32'd9);
    chk("b2b_second_diff", {24'd0, diff}, 32'hFF);
    chk("b2b_second_borrow", {31'd0, borrow_out}, 32'd1);
    repeat (4) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
